// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked ripple adder.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; never narrower than one bit so NCHUNK==1 still has a register.
  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple of full adders; c_msb is the carry into the top bit.
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per cycle via one carry register.
// Define ADDER_SUB_EN to add the sub port (a - b computed as a + ~b + 1).
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NCHUNK);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] a_chunk, b_chunk, slice_s;
  logic             slice_cout, slice_cmsb;
  logic             last_chunk;

`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  // Operand chunk select and sum chunk write-back, both steered by idx_q.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    sum_d   = sum_q;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
        sum_d[i*CHUNK +: CHUNK] = slice_s;
      end
    end
  end

  adder_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .c_msb(slice_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx_q   <= '0;
          end
        end
        StRun: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IW'(1);
          if (last_chunk) begin
            cout_q <= slice_cout;
            ovf_q  <= slice_cout ^ slice_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4) against an arithmetic model.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin;
`ifdef ADDER_SUB_EN
  logic        sub;
`endif
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic; overflow from the operand/result sign rule.
  task automatic model(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_c,
                       input logic op_s, output logic [15:0] e_sum, output logic e_cout,
                       output logic e_ovf);
    logic [16:0] full;
    logic [15:0] bb;
    logic        cc;
    bb = op_b;
    cc = op_c;
`ifdef ADDER_SUB_EN
    if (op_s) begin
      bb = ~op_b;
      cc = 1'b1;
    end
`endif
    full   = {1'b0, op_a} + {1'b0, bb} + {16'd0, cc};
    e_sum  = full[15:0];
    e_cout = full[16];
    e_ovf  = (op_a[15] == bb[15]) && (full[15] != op_a[15]);
  endtask

  // Waits (bounded) for out_valid after an accept edge and checks latency and result.
  task automatic wait_result(input logic [15:0] op_a, input logic [15:0] op_b,
                             input logic op_c, input logic op_s);
    logic [15:0] e_sum;
    logic        e_cout, e_ovf;
    int          cyc;
    model(op_a, op_b, op_c, op_s, e_sum, e_cout, e_ovf);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 4);
    check("sum", {16'd0, sum}, {16'd0, e_sum});
    check("cout", {31'd0, cout}, {31'd0, e_cout});
    check("ovf", {31'd0, ovf}, {31'd0, e_ovf});
  endtask

  task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_c,
                       input logic op_s);
    check("in_ready_pre", {31'd0, in_ready}, 32'd1);
    a        = op_a;
    b        = op_b;
    cin      = op_c;
`ifdef ADDER_SUB_EN
    sub      = op_s;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(op_a, op_b, op_c, op_s);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_post", {31'd0, out_valid}, 32'd0);
    check("in_ready_post", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef ADDER_SUB_EN
    sub       = 1'b0;
`endif
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
`ifdef ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

    // Backpressure: new operands waiting while the result is held
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(16'h1111, 16'h2222, 1'b0, 1'b0);
    a        = 16'h0ABC;
    b        = 16'h0123;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_sum", {16'd0, sum}, 32'h3333);
      check("bp_cout", {31'd0, cout}, 32'd0);
      check("bp_ovf", {31'd0, ovf}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accept", {31'd0, in_ready}, 32'd0);
    wait_result(16'h0ABC, 16'h0123, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset mid-RUN aborts the operation
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
